alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the datapath ALU, with a registered result.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result and ZNCV flags: single-cycle logic/arith/shift ops
// plus an iterative shift-add multiplier that retires one multiplier bit per cycle.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             illegal_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             illegal;
    } alu_out_t;

    // Single-cycle datapath; MUL only lands here when the multiplier is disabled.
    function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        alu_out_t       r;
        logic [WIDTH:0] sum;
        logic [SHW-1:0] sh;
        r   = '0;
        sum = '0;
        sh  = b[SHW-1:0];
        case (op)
            OP_OR:   r.res = a | b;
            OP_AND:  r.res = a & b;
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                r.res   = sum[WIDTH-1:0];
                r.carry = sum[WIDTH];
                r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, a} - {1'b0, b};
                r.res   = sum[WIDTH-1:0];
                r.carry = (a < b);
                r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r.res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r.res = a << sh;
            OP_SRL:  r.res = a >> sh;
            OP_SRA:  r.res = $unsigned($signed(a) >>> sh);
            OP_MUL:  r.illegal = ~MUL_EN;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    state_e           state_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, neg_q, carry_q, ovf_q, illegal_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [SHW-1:0]   cnt_q;

    alu_out_t         alu_s;
    logic             accept_s;
    logic             mul_req_s;
    logic             mul_last_s;
    logic [WIDTH-1:0] acc_d;

    // Handshake and next-value helpers.
    always_comb begin
        ready_o    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i);
        accept_s   = valid_i && ready_o;
        mul_req_s  = (op_i == OP_MUL) && (MUL_EN == 1'b1);
        alu_s      = alu_eval(op_i, rs_i, rt_i);
        mul_last_s = (cnt_q == SHW'(WIDTH - 1));
        acc_d      = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : {WIDTH{1'b0}});
    end

    // Control FSM with registered result, flags and multiplier state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s && mul_req_s) begin
                        state_q  <= ST_MUL;
                        valid_q  <= 1'b0;
                        mcand_q  <= rs_i;
                        mplier_q <= rt_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end else if (accept_s) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b1;
                        result_q  <= alu_s.res;
                        zero_q    <= (alu_s.res == {WIDTH{1'b0}});
                        neg_q     <= alu_s.res[WIDTH-1];
                        carry_q   <= alu_s.carry;
                        ovf_q     <= alu_s.ovf;
                        illegal_q <= alu_s.illegal;
                    end else if ((state_q == ST_DONE) && ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (mul_last_s) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b1;
                        result_q  <= acc_d;
                        zero_q    <= (acc_d == {WIDTH{1'b0}});
                        neg_q     <= acc_d[WIDTH-1];
                        carry_q   <= 1'b0;
                        ovf_q     <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign neg_o     = neg_q;
    assign carry_o   = carry_q;
    assign ovf_o     = ovf_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): a 64-bit arithmetic reference model feeds an
// in-order expectation queue that a monitor drains on every result handshake.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset, valid_i, ready_o, ready_i, valid_o;
    logic [3:0]  op_i;
    logic [31:0] rs_i, rt_i, result_o;
    logic        zero_o, neg_o, carry_o, ovf_o, illegal_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z, n, c, v, ill;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic        prev_hold = 1'b0;
    logic [37:0] prev_out, cur_out;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .rs_i(rs_i), .rt_i(rt_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .neg_o(neg_o), .carry_o(carry_o), .ovf_o(ovf_o), .illegal_o(illegal_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic, truncated to 32 bits at the end.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint unsigned ua, ub, full;
        longint sa, sb, s;
        int sh;
        r  = '0;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        full = 64'h0;
        s    = 64'sd0;
        case (op)
            4'd0: full = ua | ub;
            4'd1: full = ua & ub;
            4'd2: begin
                full = ua + ub;
                r.c  = full[32];
                s    = sa + sb;
                r.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                full = ua - ub;
                r.c  = (ua < ub);
                s    = sa - sb;
                r.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: full = (sa < sb) ? 64'd1 : 64'd0;
            4'd5: full = (ua < ub) ? 64'd1 : 64'd0;
            4'd6: full = ua << sh;
            4'd7: full = ua >> sh;
            4'd8: full = longint'(sa >>> sh);
            4'd9: full = ua * ub;
            default: r.ill = 1'b1;
        endcase
        r.res = full[31:0];
        r.z   = (r.res == 32'h0);
        r.n   = r.res[31];
        return r;
    endfunction

    // Present a request (from just after a falling edge) until accepted, then log its expectation.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n       = 0;
        valid_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        #1;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_o_low required=accept op=%0d", op);
            valid_i = 1'b0;
        end else begin
            q.push_back(model(op, a, b));
        end
        @(negedge clk);
    endtask

    // Monitor: results drain the queue in order; a stalled result must hold every output.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            cur_out = {valid_o, result_o, zero_o, neg_o, carry_o, ovf_o, illegal_o};
            if (prev_hold) chk("hold_stable", 64'(cur_out), 64'(prev_out));
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%h required=no_result", result_o);
                end else begin
                    e = q.pop_front();
                    chk("result", 64'({result_o, zero_o, neg_o, carry_o, ovf_o, illegal_o}), 64'(e));
                end
            end
            prev_hold = valid_o && !ready_i;
            prev_out  = cur_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
    } vec_t;

    vec_t vecs[14] = '{
        '{4'd3, 32'h80000000, 32'h00000001}, '{4'd4, 32'hFFFFFFFF, 32'h00000001},
        '{4'd5, 32'hFFFFFFFF, 32'h00000001}, '{4'd8, 32'h80000000, 32'h00000004},
        '{4'd7, 32'h80000000, 32'h00000004}, '{4'd6, 32'h00000001, 32'h0000001F},
        '{4'd8, 32'h9ABCDEF0, 32'h00000000}, '{4'd0, 32'hF0F00000, 32'h000F0F0F},
        '{4'd1, 32'hFF00FF00, 32'h0FF00FF0}, '{4'd3, 32'h00000000, 32'h00000001},
        '{4'd2, 32'h7FFFFFFF, 32'h00000001}, '{4'd15, 32'h12345678, 32'h1},
        '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{4'd6, 32'h80000001, 32'h00000021}
    };

    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_i    = 4'd0;
        rs_i    = 32'h0;
        rt_i    = 32'h0;

        // Pin the reference model against hand-computed values.
        chk("model_add", 64'(model(4'd2, 32'hFFFFFFFF, 32'h1)), 64'({32'h0, 5'b10100}));
        chk("model_sub", 64'(model(4'd3, 32'h80000000, 32'h1)), 64'({32'h7FFFFFFF, 5'b00010}));
        chk("model_sra", 64'(model(4'd8, 32'h80000000, 32'h4)), 64'({32'hF8000000, 5'b01000}));
        chk("model_mul", 64'(model(4'd9, 32'd12345, 32'd6789)), 64'({32'd83810205, 5'b00000}));
        chk("model_ill", 64'(model(4'd15, 32'h5, 32'h6)), 64'({32'h0, 5'b10001}));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("reset_state", 64'({ready_o, valid_o, result_o, zero_o, neg_o, carry_o, ovf_o, illegal_o}),
            64'({1'b1, 1'b0, 32'h0, 5'b00000}));
        @(negedge clk);

        // Single-cycle latency with literal flags.
        send(4'd2, 32'hFFFFFFFF, 32'h00000001);
        valid_i = 1'b0;
        #2;
        chk("add_latency", 64'({valid_o, result_o, zero_o, carry_o, ovf_o}),
            64'({1'b1, 32'h0, 1'b1, 1'b1, 1'b0}));
        @(negedge clk);

        for (int i = 0; i < 14; i++) send(vecs[i].op, vecs[i].a, vecs[i].b);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // Multiply: busy for WIDTH cycles while a queued request stalls upstream.
        send(4'd9, 32'd12345, 32'd6789);
        valid_i = 1'b1;
        op_i    = 4'd2;
        rs_i    = 32'd5;
        rt_i    = 32'd6;
        for (int c = 1; c <= 32; c++) begin
            #2;
            chk("mul_busy", 64'({ready_o, valid_o}), 64'({1'b0, 1'b0}));
            @(negedge clk);
        end
        #2;
        chk("mul_done", 64'({valid_o, result_o}), 64'({1'b1, 32'd83810205}));
        send(4'd2, 32'd5, 32'd6);
        send(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        valid_i = 1'b0;
        begin
            int n;
            n = 0;
            #2;
            while (!valid_o && n < 40) begin
                @(negedge clk);
                #2;
                n++;
            end
            chk("mul_ones", 64'({valid_o, result_o}), 64'({1'b1, 32'h1}));
        end
        @(negedge clk);

        // Stream with three cycles of consumer back-pressure mid-way.
        send(4'd2, 32'd1, 32'd2);
        send(4'd2, 32'd3, 32'd4);
        ready_i = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                ready_i = 1'b1;
            end
        join_none
        send(4'd2, 32'd5, 32'd6);
        send(4'd2, 32'd7, 32'd8);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Reset in multiply cycle 10 drops the pending product.
        send(4'd9, 32'd1000, 32'd1000);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("mul_reset", 64'({ready_o, valid_o, result_o, zero_o, neg_o, carry_o, ovf_o, illegal_o}),
            64'({1'b1, 1'b0, 32'h0, 5'b00000}));
        @(negedge clk);

        send(4'd15, 32'hDEADBEEF, 32'h1);
        valid_i = 1'b0;
        #2;
        chk("illegal_op", 64'({valid_o, result_o, zero_o, illegal_o}), 64'({1'b1, 32'h0, 1'b1, 1'b1}));
        repeat (4) @(negedge clk);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
